// File: rtl/dda_pkg.sv
// Shared types, field layout and helpers for the per-column DDA traversal engine.
// Stream words are sliced with the offsets below; distances are unsigned Q8.8.
package dda_pkg;

  typedef enum logic [2:0] {IDLE, STEP, WAIT, CHECK, EMIT} state_t;

  typedef logic [15:0] q8_8_t;

  localparam int IN_W    = 95;
  localparam int OUT_W   = 39;
  localparam int COL_W   = 9;
  localparam int COORD_W = 5;
  localparam int DIST_W  = 16;
  localparam int WALL_W  = 4;

  localparam int IN_COL_LSB = 86;
  localparam int IN_MX_LSB  = 81;
  localparam int IN_MY_LSB  = 76;
  localparam int IN_SXN_BIT = 75;
  localparam int IN_SYN_BIT = 74;
  localparam int IN_SDX_LSB = 58;
  localparam int IN_SDY_LSB = 42;
  localparam int IN_DDX_LSB = 26;
  localparam int IN_DDY_LSB = 10;

  localparam logic [WALL_W-1:0] WALL_BOUNDARY = 4'hF;
  localparam q8_8_t             DIST_MAX      = 16'hFFFF;

  // Output record, MSB first: {column, perp_dist, side, wall_type, 9'b0}
  typedef struct packed {
    logic [COL_W-1:0]  col;
    q8_8_t             perp;
    logic              side;
    logic [WALL_W-1:0] wall;
    logic [8:0]        pad;
  } hit_t;

  function automatic q8_8_t sat_add(input q8_8_t a, input q8_8_t b);
    logic [DIST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DIST_W] ? DIST_MAX : s[DIST_W-1:0];
  endfunction

endpackage

// File: rtl/dda_fsm_if.sv
// AXI-stream style ray-in / hit-out bundle for the DDA engine.
interface dda_fsm_if;
  import dda_pkg::*;

  logic              dda_fsm_in_tvalid;
  logic              dda_fsm_in_tready;
  logic [IN_W-1:0]   dda_fsm_in_tdata;
  logic              dda_fsm_out_tvalid;
  logic              dda_fsm_out_tready;
  logic [OUT_W-1:0]  dda_fsm_out_tdata;
  logic              dda_fsm_out_tlast;

  modport master (
    output dda_fsm_in_tvalid, dda_fsm_in_tdata, dda_fsm_out_tready,
    input  dda_fsm_in_tready, dda_fsm_out_tvalid, dda_fsm_out_tdata, dda_fsm_out_tlast
  );

  modport slave (
    input  dda_fsm_in_tvalid, dda_fsm_in_tdata, dda_fsm_out_tready,
    output dda_fsm_in_tready, dda_fsm_out_tvalid, dda_fsm_out_tdata, dda_fsm_out_tlast
  );
endinterface

// File: rtl/dda_fsm.sv
// Per-column DDA grid walker: steps a ray through the tile map until a wall,
// the map edge, or the step budget ends it, then emits one hit record.
module dda_fsm
  import dda_pkg::*;
#(
  parameter int NUM_COLUMNS = 320,
  parameter int MAP_SIZE    = 32,
  parameter int MAP_LATENCY = 2,
  parameter int MAX_STEPS   = 64
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  dda_fsm_if.slave            axis,
  output logic [2*COORD_W-1:0] map_addr_out,
  input  logic [WALL_W-1:0]   map_data_in
);

  localparam int CW  = $clog2(MAX_STEPS + 1);
  localparam int WCW = (MAP_LATENCY > 1) ? $clog2(MAP_LATENCY) : 1;

  state_t              state, next_state;
  logic [COL_W-1:0]    col_q;
  logic [COORD_W-1:0]  mx_q, my_q, mx_nxt, my_nxt;
  logic                sxn_q, syn_q, side_q, oob_q, max_q;
  q8_8_t               sdx_q, sdy_q, ddx_q, ddy_q, perp;
  logic [WALL_W-1:0]   wall_q;
  logic [CW-1:0]       step_cnt;
  logic [WCW-1:0]      wait_cnt;
  logic                in_tready_q, out_tvalid_q, out_tlast_q;
  hit_t                out_rec_q;
  logic                accept, x_step, x_edge, y_edge, step_done, wait_done;

  assign accept    = (state == IDLE) && axis.dda_fsm_in_tvalid && in_tready_q;
  assign x_step    = sdx_q < sdy_q;
  assign mx_nxt    = sxn_q ? mx_q - COORD_W'(1) : mx_q + COORD_W'(1);
  assign my_nxt    = syn_q ? my_q - COORD_W'(1) : my_q + COORD_W'(1);
  // Edge test happens on the pre-step coordinate so a wrap is never mistaken for in-map.
  assign x_edge    = sxn_q ? (mx_q == '0) : (mx_q == COORD_W'(MAP_SIZE - 1));
  assign y_edge    = syn_q ? (my_q == '0) : (my_q == COORD_W'(MAP_SIZE - 1));
  assign step_done = step_cnt == CW'(MAX_STEPS);
  assign wait_done = wait_cnt == WCW'(MAP_LATENCY - 1);

  always_comb begin
    perp = side_q ? sdy_q - ddy_q : sdx_q - ddx_q;
    if (max_q || (side_q ? sdy_q : sdx_q) == DIST_MAX) perp = DIST_MAX;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = STEP;
      STEP:  next_state = WAIT;
      WAIT:  if (wait_done) next_state = CHECK;
      CHECK: next_state = (oob_q || map_data_in != '0 || step_done) ? EMIT : STEP;
      EMIT:  if (out_tvalid_q && axis.dda_fsm_out_tready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      col_q <= '0; mx_q <= '0; my_q <= '0; sxn_q <= 1'b0; syn_q <= 1'b0;
      sdx_q <= '0; sdy_q <= '0; ddx_q <= '0; ddy_q <= '0;
      side_q <= 1'b0; oob_q <= 1'b0; max_q <= 1'b0; wall_q <= '0;
      step_cnt <= '0; wait_cnt <= '0; map_addr_out <= '0;
      in_tready_q <= 1'b0; out_tvalid_q <= 1'b0; out_tlast_q <= 1'b0; out_rec_q <= '0;
    end else begin
      in_tready_q <= (next_state == IDLE);
      case (state)
        IDLE: if (accept) begin
          col_q    <= axis.dda_fsm_in_tdata[IN_COL_LSB +: COL_W];
          mx_q     <= axis.dda_fsm_in_tdata[IN_MX_LSB +: COORD_W];
          my_q     <= axis.dda_fsm_in_tdata[IN_MY_LSB +: COORD_W];
          sxn_q    <= axis.dda_fsm_in_tdata[IN_SXN_BIT];
          syn_q    <= axis.dda_fsm_in_tdata[IN_SYN_BIT];
          sdx_q    <= axis.dda_fsm_in_tdata[IN_SDX_LSB +: DIST_W];
          sdy_q    <= axis.dda_fsm_in_tdata[IN_SDY_LSB +: DIST_W];
          ddx_q    <= axis.dda_fsm_in_tdata[IN_DDX_LSB +: DIST_W];
          ddy_q    <= axis.dda_fsm_in_tdata[IN_DDY_LSB +: DIST_W];
          step_cnt <= '0;
          oob_q    <= 1'b0;
          max_q    <= 1'b0;
        end
        STEP: begin
          if (x_step) begin
            sdx_q        <= sat_add(sdx_q, ddx_q);
            mx_q         <= mx_nxt;
            side_q       <= 1'b0;
            oob_q        <= x_edge;
            map_addr_out <= {my_q, mx_nxt};
          end else begin
            sdy_q        <= sat_add(sdy_q, ddy_q);
            my_q         <= my_nxt;
            side_q       <= 1'b1;
            oob_q        <= y_edge;
            map_addr_out <= {my_nxt, mx_q};
          end
          step_cnt <= step_cnt + CW'(1);
          wait_cnt <= '0;
        end
        WAIT: wait_cnt <= wait_cnt + WCW'(1);
        CHECK: begin
          // max_q only matters when step_done also routes us to EMIT.
          max_q  <= !oob_q && map_data_in == '0;
          wall_q <= oob_q ? WALL_BOUNDARY : map_data_in;
        end
        EMIT: begin
          if (!out_tvalid_q) begin
            out_tvalid_q <= 1'b1;
            out_tlast_q  <= col_q == COL_W'(NUM_COLUMNS - 1);
            out_rec_q    <= '{col: col_q, perp: perp, side: side_q, wall: wall_q, pad: '0};
          end else if (axis.dda_fsm_out_tready) begin
            out_tvalid_q <= 1'b0;
            out_tlast_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign axis.dda_fsm_in_tready  = in_tready_q;
  assign axis.dda_fsm_out_tvalid = out_tvalid_q;
  assign axis.dda_fsm_out_tdata  = out_rec_q;
  assign axis.dda_fsm_out_tlast  = out_tlast_q;

endmodule

// File: tb/tb_dda_fsm.sv
// Scoreboard bench for dda_fsm: directed rays, 2-cycle map BRAM model, decoupled monitor.
module tb_dda_fsm;
  import dda_pkg::*;

  localparam int MAX_ST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] map_addr;
  logic [3:0] map_data, stage1;
  logic [3:0] tiles [0:1023];
  int         cyc = 0;

  dda_fsm_if bus();

  dda_fsm #(.NUM_COLUMNS(320), .MAP_SIZE(32), .MAP_LATENCY(2), .MAX_STEPS(MAX_ST)) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .axis         (bus),
    .map_addr_out (map_addr),
    .map_data_in  (map_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    stage1   <= tiles[map_addr];
    map_data <= stage1;
  end

  typedef struct {
    logic [38:0] data;
    logic        last;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0, n_rec = 0, n_sent = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [94:0] mk_ray(input int col, input int mx, input int my,
      input bit sxn, input bit syn, input int sdx, input int sdy, input int ddx, input int ddy);
    return {9'(col), 5'(mx), 5'(my), sxn, syn, 16'(sdx), 16'(sdy), 16'(ddx), 16'(ddy), 10'b0};
  endfunction

  function automatic logic [38:0] mk_hit(input int col, input int perp, input bit side, input int wall);
    return {9'(col), 16'(perp), side, 4'(wall), 9'b0};
  endfunction

  task automatic clear_map();
    for (int i = 0; i < 1024; i++) tiles[i] = 4'h0;
  endtask

  task automatic send_ray(input logic [94:0] d, input logic [38:0] hit, input bit last,
                          input int lat, input bit push);
    exp_t e;
    int   n = 0;
    @(posedge clk); #1;
    bus.dda_fsm_in_tdata  = d;
    bus.dda_fsm_in_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.dda_fsm_in_tready && n < 300) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    chk("in_accept_timeout", {63'd0, bus.dda_fsm_in_tready}, 64'd1);
    if (bus.dda_fsm_in_tready && push) begin
      e.data = hit; e.last = last; e.acc = cyc + 1; e.lat = lat;
      sb.push_back(e);
      n_sent++;
    end
    @(posedge clk); #1;
    bus.dda_fsm_in_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: one pop per output handshake, plus hold-stability while stalled.
  bit          seen = 1'b0, unstable = 1'b0;
  int          rise = 0;
  logic [38:0] held_d;
  logic        held_l;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) seen = 1'b0;
    else if (bus.dda_fsm_out_tvalid) begin
      if (!seen) begin
        seen = 1'b1; rise = cyc; unstable = 1'b0;
        held_d = bus.dda_fsm_out_tdata; held_l = bus.dda_fsm_out_tlast;
      end else if (bus.dda_fsm_out_tdata !== held_d || bus.dda_fsm_out_tlast !== held_l)
        unstable = 1'b1;
      if (bus.dda_fsm_in_tready) unstable = 1'b1;
      if (bus.dda_fsm_out_tready) begin
        seen = 1'b0;
        n_rec++;
        if (sb.size() == 0) chk("extra_record", 64'(sb.size()), 64'd1);
        else begin
          e = sb.pop_front();
          chk("rec_data", 64'(bus.dda_fsm_out_tdata), 64'(e.data));
          chk("rec_last", 64'(bus.dda_fsm_out_tlast), 64'(e.last));
          chk("rec_latency", 64'(rise - e.acc), 64'(e.lat));
          chk("rec_stable", 64'(unstable), 64'd0);
        end
      end
    end
  end

  initial begin
    int n;
    bus.dda_fsm_in_tvalid  = 1'b0;
    bus.dda_fsm_in_tdata   = '0;
    bus.dda_fsm_out_tready = 1'b1;
    clear_map();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_tready",  64'(bus.dda_fsm_in_tready), 64'd0);
    chk("rst_out_tvalid", 64'(bus.dda_fsm_out_tvalid), 64'd0);
    chk("rst_out_tdata",  64'(bus.dda_fsm_out_tdata), 64'd0);
    chk("rst_out_tlast",  64'(bus.dda_fsm_out_tlast), 64'd0);
    chk("rst_map_addr",   64'(map_addr), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("tready_first_cycle", 64'(bus.dda_fsm_in_tready), 64'd0);
    @(negedge clk);
    chk("tready_idle", 64'(bus.dda_fsm_in_tready), 64'd1);

    // single hit on x side
    clear_map(); tiles[{5'd5, 5'd6}] = 4'h3;
    send_ray(mk_ray(10, 5, 5, 0, 0, 'h0080, 'h0200, 'h0100, 'h0100), mk_hit(10, 'h0080, 0, 3), 0, 5, 1);
    drain();
    chk("map_addr_hold", 64'(map_addr), 64'({5'd5, 5'd6}));

    // tie resolves to y
    clear_map(); tiles[{5'd6, 5'd5}] = 4'h2;
    send_ray(mk_ray(11, 5, 5, 0, 0, 'h0100, 'h0100, 'h0100, 'h0100), mk_hit(11, 'h0100, 1, 2), 0, 5, 1);
    drain();

    // x underflow off the west edge; wrapped tile must be ignored
    clear_map(); tiles[{5'd7, 5'd31}] = 4'h5;
    send_ray(mk_ray(12, 0, 7, 1, 0, 'h0040, 'h0300, 'h0100, 'h0100), mk_hit(12, 'h0040, 0, 15), 0, 5, 1);
    drain();

    // step budget exhausted in open map: x,y,x,y
    clear_map();
    send_ray(mk_ray(13, 10, 10, 0, 0, 'h0080, 'h00C0, 'h0100, 'h0100), mk_hit(13, 'hFFFF, 1, 0), 0,
             MAX_ST * 4 + 1, 1);
    drain();

    // saturating add, out-of-range column without tlast
    clear_map(); tiles[{5'd5, 5'd6}] = 4'h1;
    send_ray(mk_ray(400, 5, 5, 0, 0, 'hFF80, 'hFFF0, 'h0100, 'h0100), mk_hit(400, 'hFFFF, 0, 1), 0, 5, 1);
    drain();

    // backpressure on last column
    clear_map(); tiles[{5'd5, 5'd6}] = 4'h7;
    bus.dda_fsm_out_tready = 1'b0;
    send_ray(mk_ray(319, 5, 5, 0, 0, 'h0010, 'h0020, 'h0300, 'h0100), mk_hit(319, 'h0010, 0, 7), 1, 5, 1);
    n = 0;
    @(negedge clk);
    while (!bus.dda_fsm_out_tvalid && n < 100) begin @(negedge clk); n++; end
    chk("bp_tvalid_seen", 64'(bus.dda_fsm_out_tvalid), 64'd1);
    repeat (20) @(negedge clk);
    chk("bp_held_valid", 64'(bus.dda_fsm_out_tvalid), 64'd1);
    @(posedge clk); #1 bus.dda_fsm_out_tready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    chk("bp_single_transfer", 64'(bus.dda_fsm_out_tvalid), 64'd0);

    // reset while waiting on the map read
    clear_map(); tiles[{5'd5, 5'd6}] = 4'h3;
    send_ray(mk_ray(20, 5, 5, 0, 0, 'h0080, 'h0200, 'h0100, 'h0100), mk_hit(20, 'h0080, 0, 3), 0, 5, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_tvalid", 64'(bus.dda_fsm_out_tvalid), 64'd0);
    chk("midrst_in_tready",  64'(bus.dda_fsm_in_tready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_tready_back", 64'(bus.dda_fsm_in_tready), 64'd1);
    send_ray(mk_ray(21, 5, 5, 0, 0, 'h0080, 'h0200, 'h0100, 'h0100), mk_hit(21, 'h0080, 0, 3), 0, 5, 1);
    drain();
    repeat (10) @(negedge clk);

    chk("record_count", 64'(n_rec), 64'(n_sent));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
